// File: rtl/dcache_load_sequencer.sv
// Load sequencer between the MEM stage and the dcache: word-aligned reads, byte/half/word extraction,
// sign/zero extension. Define DCACHE_LOAD_SPLIT_EN to split word-straddling loads into two reads.
module dcache_load_sequencer #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_resp
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD0  = 2'd1;
    localparam logic [1:0] S_RD1  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    logic [1:0]            state_q, state_d;
    logic [1:0]            offset_q, offset_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  req_ready_d;
    logic                  resp_valid_d;
    logic [31:0]           resp_data_d;
    logic                  resp_err_d;
    logic                  mem_read_d;
    logic [ADDR_WIDTH-1:0] mem_address_d;
`ifdef DCACHE_LOAD_SPLIT_EN
    logic [31:0]           w0_q, w0_d;
`endif

    function automatic logic is_legal(input logic [2:0] f3);
        return (f3 == F_LB) || (f3 == F_LH) || (f3 == F_LW) || (f3 == F_LBU) || (f3 == F_LHU);
    endfunction

    // Load crosses into the next word: any unaligned lw, or a halfword starting at byte 3.
    function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == F_LW) && (off != 2'd0)) ||
               (((f3 == F_LH) || (f3 == F_LHU)) && (off == 2'd3));
    endfunction

    // Shift the {w1,w0} pair down to the addressed byte and extend to 32 bits.
    function automatic logic [31:0] merge(input logic [63:0] pair, input logic [1:0] off,
                                          input logic [2:0] f3);
        logic [31:0] t;
        t = 32'(pair >> {off, 3'b000});
        case (f3)
            F_LB:    return {{24{t[7]}}, t[7:0]};
            F_LBU:   return {24'h0, t[7:0]};
            F_LH:    return {{16{t[15]}}, t[15:0]};
            F_LHU:   return {16'h0, t[15:0]};
            default: return t;
        endcase
    endfunction

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d       = state_q;
        offset_d      = offset_q;
        funct3_d      = funct3_q;
        req_ready_d   = req_ready;
        resp_valid_d  = resp_valid;
        resp_data_d   = resp_data;
        resp_err_d    = resp_err;
        mem_read_d    = mem_read;
        mem_address_d = mem_address;
`ifdef DCACHE_LOAD_SPLIT_EN
        w0_d          = w0_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    offset_d      = req_addr[1:0];
                    funct3_d      = req_funct3;
                    mem_address_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    req_ready_d   = 1'b0;
`ifdef DCACHE_LOAD_SPLIT_EN
                    if (!is_legal(req_funct3)) begin
`else
                    if (!is_legal(req_funct3) || is_split(req_funct3, req_addr[1:0])) begin
`endif
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = 32'h0;
                    end else begin
                        state_d    = S_RD0;
                        mem_read_d = 1'b1;
                    end
                end
            end

            S_RD0: begin
                if (mem_resp) begin
                    mem_read_d = 1'b0;
`ifdef DCACHE_LOAD_SPLIT_EN
                    if (is_split(funct3_q, offset_q)) begin
                        w0_d          = mem_rdata;
                        state_d       = S_RD1;
                        mem_address_d = ADDR_WIDTH'(mem_address + ADDR_WIDTH'(4));
                    end else begin
                        state_d      = S_DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_data_d  = merge({32'h0, mem_rdata}, offset_q, funct3_q);
                    end
`else
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = merge({32'h0, mem_rdata}, offset_q, funct3_q);
`endif
                end
            end

`ifdef DCACHE_LOAD_SPLIT_EN
            // Entered with mem_read low for one cycle; only a response to the raised strobe counts.
            S_RD1: begin
                if (mem_read && mem_resp) begin
                    mem_read_d   = 1'b0;
                    state_d      = S_DONE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = merge({mem_rdata, w0_q}, offset_q, funct3_q);
                end else begin
                    mem_read_d = 1'b1;
                end
            end
`endif

            S_DONE: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
                mem_read_d   = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            offset_q    <= 2'd0;
            funct3_q    <= 3'd0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_data   <= 32'h0;
            resp_err    <= 1'b0;
            mem_read    <= 1'b0;
            mem_address <= '0;
`ifdef DCACHE_LOAD_SPLIT_EN
            w0_q        <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            funct3_q    <= funct3_d;
            req_ready   <= req_ready_d;
            resp_valid  <= resp_valid_d;
            resp_data   <= resp_data_d;
            resp_err    <= resp_err_d;
            mem_read    <= mem_read_d;
            mem_address <= mem_address_d;
`ifdef DCACHE_LOAD_SPLIT_EN
            w0_q        <= w0_d;
`endif
        end
    end

endmodule

// File: doc/dcache_load_sequencer.md
Name: dcache_load_sequencer

Overview:
- Sequences every load from the pipeline MEM stage into the dcache.
- Issues word-aligned cache reads and waits for `mem_resp`. Extracts the byte, halfword or word and sign/zero-extends it per funct3.
- Splits misaligned loads that straddle a word boundary into two cache reads and merges the result.
- Holds the result until the pipeline accepts it.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses on both sides; second-word address arithmetic is modulo 2^ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset (sampled on rising edge of clk).
- req_valid  in  1  load request present.
- req_ready  out  1  sequencer can accept a request.
- req_addr  in  ADDR_WIDTH  byte address of load.
- req_funct3  in  3  load type: lb=000, lh=001, lw=010, lbu=100, lhu=101.
- resp_valid  out  1  result available.
- resp_ready  in  1  pipeline consumes result.
- resp_data  out  32  extended load data.
- resp_err  out  1  illegal funct3, or misaligned load when the split feature is absent.
- mem_read  out  1  dcache read strobe.
- mem_address  out  ADDR_WIDTH  word-aligned address; bits [1:0] always 0.
- mem_rdata  in  32  dcache read data.
- mem_resp  in  1  dcache read complete, one-cycle pulse.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_data=0; mem_read=0; mem_address=0; internal word/offset/funct3 registers cleared.
- States: IDLE, RD0, RD1, DONE. req_ready = (state==IDLE).
- IDLE, on req_valid: latch addr[1:0] as offset, funct3, and word address addr & ~3.
  - Legal funct3: go to RD0.
  - Illegal funct3 (011/110/111): go to DONE with resp_err=1, resp_data=0, and no cache access.
- Split condition: (lw and offset!=0) or (lh/lhu and offset==3). Byte loads never split.
- RD0: mem_read=1, mem_address=word address. mem_read is registered and first seen the cycle after acceptance. Hold until mem_resp.
  - On mem_resp, capture w0.
  - Split: go to RD1 with mem_address += 4 (wraps 0xFFFFFFFC -> 0x0).
  - Otherwise go to DONE.
- RD1: mem_read=1 at the second address; on mem_resp capture w1, go to DONE.
- mem_read drops to 0 the cycle after each mem_resp. There is exactly one deassert cycle between the RD0 and RD1 reads.
- Merge: t = ({w1,w0} >> 8*offset)[31:0], with w1 treated as 0 when not split.
  - lb: sign-extend t[7:0]; lbu: zero-extend t[7:0].
  - lh: sign-extend t[15:0]; lhu: zero-extend t[15:0].
  - lw: t.
- DONE: resp_valid=1; resp_data/resp_err stable until the cycle resp_ready=1, then go to IDLE.
  - No new request is accepted in the same cycle as the DONE handoff.
- Latency (aligned, mem_resp on first read cycle): accept at T, mem_read at T+1, resp_valid at T+2.
- mem_resp while in IDLE or DONE: ignored.
- Reset mid-operation: next cycle IDLE, mem_read=0, resp_valid=0, captured data discarded. A late mem_resp is ignored.
- Inputs are not sampled outside IDLE; req_* may change freely while busy.

Optional Feature:
- Macro DCACHE_LOAD_SPLIT_EN.
- Defined: split behaviour as above.
- Undefined: a load meeting the split condition makes no cache access, goes IDLE -> DONE with resp_err=1 and resp_data=0. RD1 and w1 logic are not built.
- All other loads behave identically in both builds.

Test Plan:
Memory model preloaded with [0x100]=0x8899AABB and [0x104]=0x11223344; mem_resp 2 cycles after each mem_read.
- lb @0x103 -> one read at 0x100; resp_data=0xFFFFFF88, resp_err=0.
- lhu @0x102 -> resp_data=0x00008899; lh @0x100 -> 0xFFFFAABB.
- lw @0x102 with EN -> reads 0x100 then 0x104, resp_data=0x33448899. Without EN -> no mem_read, resp_err=1, resp_data=0.
- lh @0x103 with EN -> two reads, resp_data=0x00004488. lw @0xFFFFFFFE -> second read at 0x00000000.
- funct3=011 @0x100 -> no mem_read; resp_valid with resp_err=1, data 0. With resp_ready held low 5 cycles, outputs stay stable and req_ready stays 0.
- rst_n=0 during RD1 -> next cycle mem_read=0, resp_valid=0, req_ready=1. A stray mem_resp after reset produces no response.
